// File: rtl/nn_vga_dot_ctrl_pkg.sv
// nn_vga_pkg: VGA 640x480@60 timing constants, colour levels and dot span helper
package nn_vga_pkg;
  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int DOT_SIZE = 8;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0] COLOUR_ON = 4'hF;
  localparam logic [3:0] GRID_LVL  = 4'h4;
  function automatic logic in_span(input logic [10:0] p, input logic [31:0] start, input int lim, input int size);
    return start < 32'(lim) && p >= start[10:0] && {1'b0, p} < {1'b0, start[10:0]} + 12'(size);
  endfunction
endpackage

// File: rtl/nn_vga_dot_ctrl_if.sv
// nn_vga_dot_ctrl_if: SoC VGA coordinate registers; master = SoC, slave = dot controller
interface nn_vga_dot_ctrl_if;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [31:0] x_g;
  logic [31:0] y_g;
  modport master(output x_r, y_r, x_g, y_g);
  modport slave(input x_r, y_r, x_g, y_g);
endinterface

// File: rtl/nn_vga_dot_ctrl_timing.sv
// nn_vga_timing: pixel divider, h/v counters, sync levels, active flag and frame-end strobe (CLK, RST_N sync active-low; outputs pe, h, v, hs, vs, active, frame_end)
module nn_vga_timing import nn_vga_pkg::*; #(
  parameter int P_CLK_DIV  = CLK_DIV,
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        pe,
  output logic [10:0] h,
  output logic [10:0] v,
  output logic        hs,
  output logic        vs,
  output logic        active,
  output logic        frame_end
);
  localparam logic [7:0]  DIV_END = 8'(P_CLK_DIV - 1);
  localparam logic [10:0] HA  = 11'(P_H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(P_H_ACTIVE + P_H_FP);
  localparam logic [10:0] HS1 = 11'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
  localparam logic [10:0] HT1 = 11'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [10:0] VA  = 11'(P_V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(P_V_ACTIVE + P_V_FP);
  localparam logic [10:0] VS1 = 11'(P_V_ACTIVE + P_V_FP + P_V_SYNC);
  localparam logic [10:0] VT1 = 11'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
  logic [7:0] div;
  logic h_end;
  assign pe        = div == DIV_END;
  assign h_end     = h == HT1;
  assign hs        = !(h >= HS0 && h < HS1);
  assign vs        = !(v >= VS0 && v < VS1);
  assign active    = h < HA && v < VA;
  assign frame_end = pe && h_end && v == VA - 11'd1;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= pe ? '0 : div + 8'd1;
      if (pe) h <= h_end ? '0 : h + 11'd1;
      if (pe && h_end) v <= v == VT1 ? '0 : v + 11'd1;
    end
  end
endmodule

// File: rtl/nn_vga_dot_ctrl.sv
// nn_vga_dot_ctrl: VGA timing plus red/green dots from per-frame shadowed SoC coordinates (CLK, RST_N sync active-low, bus slave coords in; VGA_HS/VS/R/G/B, FRAME_TICK out; NN_VGA_GRID_EN adds a dim blue 64-px grid)
module nn_vga_dot_ctrl import nn_vga_pkg::*; #(
  parameter int P_CLK_DIV  = CLK_DIV,
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP,
  parameter int P_DOT_SIZE = DOT_SIZE
) (
  input  logic              CLK,
  input  logic              RST_N,
  nn_vga_dot_ctrl_if.slave  bus,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              FRAME_TICK
);
  logic pe, hs, vs, active, frame_end, hit_r, hit_g;
  logic [10:0] h, v;
  logic [31:0] x_r, y_r, x_g, y_g;
  nn_vga_timing #(
    .P_CLK_DIV(P_CLK_DIV), .P_H_ACTIVE(P_H_ACTIVE), .P_H_FP(P_H_FP), .P_H_SYNC(P_H_SYNC), .P_H_BP(P_H_BP),
    .P_V_ACTIVE(P_V_ACTIVE), .P_V_FP(P_V_FP), .P_V_SYNC(P_V_SYNC), .P_V_BP(P_V_BP)
  ) u_timing (
    .CLK(CLK), .RST_N(RST_N), .pe(pe), .h(h), .v(v), .hs(hs), .vs(vs), .active(active), .frame_end(frame_end)
  );
  // in_span also hides dots whose shadow coordinate lies past the visible area
  assign hit_r = active && in_span(h, x_r, P_H_ACTIVE, P_DOT_SIZE) && in_span(v, y_r, P_V_ACTIVE, P_DOT_SIZE);
  assign hit_g = active && in_span(h, x_g, P_H_ACTIVE, P_DOT_SIZE) && in_span(v, y_g, P_V_ACTIVE, P_DOT_SIZE);
  // shadows load on the last pixel of the last active line, so the whole next frame sees one coherent set
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_r <= '0;
      y_r <= '0;
      x_g <= '0;
      y_g <= '0;
    end else if (frame_end) begin
      x_r <= bus.x_r;
      y_r <= bus.y_r;
      x_g <= bus.x_g;
      y_g <= bus.y_g;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_R      <= '0;
      VGA_G      <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= frame_end;
      if (pe) begin
        VGA_HS <= hs;
        VGA_VS <= vs;
        VGA_R  <= hit_r ? COLOUR_ON : '0;
        VGA_G  <= hit_g ? COLOUR_ON : '0;
      end
    end
  end
`ifdef NN_VGA_GRID_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) VGA_B <= '0;
    else if (pe) VGA_B <= active && !hit_r && !hit_g && (h[5:0] == 6'd0 || v[5:0] == 6'd0) ? GRID_LVL : '0;
  end
`else
  assign VGA_B = '0;
`endif
endmodule
